// File: rtl/riscv_prefetch_pkg.sv
// ============================================================================
//  Module  : riscv_prefetch_pkg
//  Brief   : Shared types for the instruction prefetch controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_prefetch_pkg;

    localparam int c_CNT_W = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        first;
        logic        hwlp;
    } fetch_tag_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } prefetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_prefetch_tag_fifo.sv
// ============================================================================
//  Module  : riscv_prefetch_tag_fifo
//  Brief   : Shallow in-order tag queue for granted-but-unreturned fetches.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_prefetch_tag_fifo
    import riscv_prefetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  fetch_tag_t         i_push_tag,
    input  logic               i_pop,
    output fetch_tag_t         o_head_tag,
    output logic [c_CNT_W-1:0] o_count
);

    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    fetch_tag_t         r_mem [DEPTH];
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_wr_idx;

    // A same-cycle pop shifts the queue down, so the write slot moves with it.
    assign w_wr_idx = r_count - c_CNT_W'(i_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (w_wr_idx == c_CNT_W'(i))) begin
                    r_mem[i] <= i_push_tag;
                end
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_tag = r_mem[0];
    assign o_count    = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && (r_count == c_DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && (r_count == '0)));

endmodule

`default_nettype wire

// File: rtl/riscv_prefetch_ctrl.sv
// ============================================================================
//  Module  : riscv_prefetch_ctrl
//  Brief   : Instruction fetch request/response controller feeding the fetch
//            FIFO. Optional hardware-loop redirect: PREFETCH_HWLP_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_prefetch_ctrl
    import riscv_prefetch_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        hwlp_jump_i,
    input  logic [31:0] hwlp_target_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        fifo_ready_i,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_clear_o,
    output logic        fifo_replace2_o,
    output logic        fifo_is_hwlp_o,
    output logic        busy_o
);

    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_OUTSTANDING);

    prefetch_state_e    r_state;
    logic [31:0]        r_fetch_addr;
    logic [31:0]        r_instr_addr;
    logic               r_first;
    logic               r_hwlp;
    fetch_tag_t         r_cur_tag;
    logic [c_CNT_W-1:0] r_discard;
    logic               r_pending_discard;

    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic [c_CNT_W-1:0] w_discard_next;
    logic               w_pending_next;
    fetch_tag_t         w_head;
    fetch_tag_t         w_issue_tag;
    logic [31:0]        w_fetch_aligned;
    logic [31:0]        w_redirect_addr;
    logic               w_hwlp_redirect;
    logic               w_redirect;
    logic               w_grant;
    logic               w_issue_ok;
    logic               w_push_fifo;
    logic               w_unused;

`ifdef PREFETCH_HWLP_EN
    assign w_hwlp_redirect = hwlp_jump_i && !branch_i;
    assign w_redirect_addr = branch_i ? branch_addr_i : hwlp_target_i;
    assign fifo_replace2_o = w_push_fifo && w_head.hwlp;
    assign fifo_is_hwlp_o  = w_push_fifo && w_head.hwlp;
    assign w_unused        = w_head.first;
`else
    assign w_hwlp_redirect = 1'b0;
    assign w_redirect_addr = branch_addr_i;
    assign fifo_replace2_o = 1'b0;
    assign fifo_is_hwlp_o  = 1'b0;
    assign w_unused        = ^{w_head.first, w_head.hwlp, hwlp_jump_i, hwlp_target_i};
`endif

    assign w_redirect      = branch_i || w_hwlp_redirect;
    assign w_grant         = (r_state == REQ) && instr_gnt_i;
    assign w_fetch_aligned = align_word(r_fetch_addr);

    always_comb begin
        w_count_next = w_count;
        case ({w_grant, instr_rvalid_i})
            2'b10:   w_count_next = w_count + 1'b1;
            2'b01:   w_count_next = w_count - 1'b1;
            default: w_count_next = w_count;
        endcase
    end

    // Only the first word after a redirect keeps the halfword offset.
    always_comb begin
        w_issue_tag       = '0;
        w_issue_tag.addr  = r_first ? {r_fetch_addr[31:1], 1'b0} : w_fetch_aligned;
        w_issue_tag.first = r_first;
        w_issue_tag.hwlp  = r_hwlp;
    end

    assign w_issue_ok  = req_i && fifo_ready_i && (w_count_next < c_MAX) && !w_redirect;
    assign w_push_fifo = instr_rvalid_i && !w_redirect && (r_discard == '0);

    // Everything in flight after this cycle becomes stale on a redirect; a
    // request still waiting for grant is counted once it is granted.
    always_comb begin
        w_discard_next = r_discard;
        w_pending_next = r_pending_discard;
        if (w_redirect) begin
            w_discard_next = w_count_next;
            w_pending_next = (r_state == REQ) && !instr_gnt_i;
        end else begin
            if (instr_rvalid_i && (r_discard != '0)) begin
                w_discard_next = w_discard_next - 1'b1;
            end
            if (w_grant && r_pending_discard) begin
                w_discard_next = w_discard_next + 1'b1;
                w_pending_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_fetch_addr      <= '0;
            r_instr_addr      <= '0;
            r_first           <= 1'b0;
            r_hwlp            <= 1'b0;
            r_cur_tag         <= '0;
            r_discard         <= '0;
            r_pending_discard <= 1'b0;
        end else begin
            r_discard         <= w_discard_next;
            r_pending_discard <= w_pending_next;
            if (w_redirect) begin
                r_fetch_addr <= w_redirect_addr;
                r_first      <= 1'b1;
                r_hwlp       <= w_hwlp_redirect;
                if (w_grant) begin
                    r_state <= IDLE;
                end
            end else if (((r_state == IDLE) || w_grant) && w_issue_ok) begin
                r_state      <= REQ;
                r_instr_addr <= w_fetch_aligned;
                r_cur_tag    <= w_issue_tag;
                r_fetch_addr <= w_fetch_aligned + 32'd4;
                r_first      <= 1'b0;
                r_hwlp       <= 1'b0;
            end else if (w_grant) begin
                r_state <= IDLE;
            end
        end
    end

    riscv_prefetch_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_grant),
        .i_push_tag (r_cur_tag),
        .i_pop      (instr_rvalid_i),
        .o_head_tag (w_head),
        .o_count    (w_count)
    );

    assign instr_req_o  = (r_state == REQ);
    assign instr_addr_o = r_instr_addr;
    assign fifo_valid_o = w_push_fifo;
    assign fifo_addr_o  = w_push_fifo ? w_head.addr : '0;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_clear_o = branch_i;
    assign busy_o       = instr_req_o || (w_count != '0);

endmodule

`default_nettype wire
